// File: rtl/bank_cmd_timing_arbiter_if.sv
// Request/command bundle between the per-bank FSMs, the timing arbiter and the PHY command bus.
// master = bank-FSM side (drives requests, sees stall and the bus); slave = the arbiter.
interface bank_cmd_timing_arbiter_if #(
  parameter int NUM_BANKS = 8,
  parameter int ADDR_W    = 16
);
  localparam int BANK_W = $clog2(NUM_BANKS);

  logic [NUM_BANKS-1:0]        req_valid;
  logic [3*NUM_BANKS-1:0]      req_cmd;
  logic [ADDR_W*NUM_BANKS-1:0] req_addr;
  logic [NUM_BANKS-1:0]        stall;
  logic                        cmd_valid;
  logic [2:0]                  cmd_code;
  logic [BANK_W-1:0]           cmd_bank;
  logic [ADDR_W-1:0]           cmd_addr;

  modport master (
    output req_valid, req_cmd, req_addr,
    input  stall, cmd_valid, cmd_code, cmd_bank, cmd_addr
  );

  modport slave (
    input  req_valid, req_cmd, req_addr,
    output stall, cmd_valid, cmd_code, cmd_bank, cmd_addr
  );
endinterface

// File: rtl/bank_cmd_timing_arbiter.sv
// Per-bank and cross-bank DRAM timing checker with round-robin grant of one command per cycle.
// Timers count down to zero; a command is eligible once every timer it depends on reads zero.
module bank_cmd_timing_arbiter #(
  parameter int NUM_BANKS = 8,
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 6,
  parameter int T_RCD     = 4,
  parameter int T_RP      = 4,
  parameter int T_RAS     = 10,
  parameter int T_WR      = 5,
  parameter int T_RFC     = 20,
  parameter int T_CCD     = 2,
  parameter int T_RRD     = 2
) (
  input logic clk,
  input logic rst_n,
  bank_cmd_timing_arbiter_if.slave bus
);
  localparam int BANK_W = $clog2(NUM_BANKS);

  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  // Load values are T-1, clamped so that T=0 behaves like T=1.
  localparam logic [CNT_W-1:0] LD_RCD = (T_RCD > 0) ? CNT_W'(T_RCD - 1) : '0;
  localparam logic [CNT_W-1:0] LD_RP  = (T_RP  > 0) ? CNT_W'(T_RP  - 1) : '0;
  localparam logic [CNT_W-1:0] LD_RAS = (T_RAS > 0) ? CNT_W'(T_RAS - 1) : '0;
  localparam logic [CNT_W-1:0] LD_WR  = (T_WR  > 0) ? CNT_W'(T_WR  - 1) : '0;
  localparam logic [CNT_W-1:0] LD_RFC = (T_RFC > 0) ? CNT_W'(T_RFC - 1) : '0;
  localparam logic [CNT_W-1:0] LD_CCD = (T_CCD > 0) ? CNT_W'(T_CCD - 1) : '0;
  localparam logic [CNT_W-1:0] LD_RRD = (T_RRD > 0) ? CNT_W'(T_RRD - 1) : '0;

  function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] max_t(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [CNT_W-1:0]     ccd_t;
  logic [CNT_W-1:0]     rrd_t;
  logic [NUM_BANKS-1:0] legal;
  logic [NUM_BANKS-1:0] elig;
  logic [NUM_BANKS-1:0] grant_onehot;
  logic [BANK_W-1:0]    rr_ptr;
  logic                 grant_valid;
  logic [BANK_W-1:0]    grant_idx;
  logic [2:0]           grant_code;
  logic [ADDR_W-1:0]    grant_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [2:0]       code;
      logic [CNT_W-1:0] rd_wr_t;
      logic [CNT_W-1:0] act_t;
      logic [CNT_W-1:0] pre_t;
      logic             hit;

      assign code = bus.req_cmd[3*gi +: 3];
      assign legal[gi] = bus.req_valid[gi] && (code >= CMD_ACT) && (code <= CMD_REF);
      assign hit = grant_valid && (grant_idx == BANK_W'(gi));
      assign grant_onehot[gi] = hit;

      always_comb begin
        elig[gi] = 1'b0;
        if (legal[gi]) begin
          case (code)
            CMD_ACT:        elig[gi] = (act_t == '0) && (rrd_t == '0);
            CMD_RD, CMD_WR: elig[gi] = (rd_wr_t == '0) && (ccd_t == '0);
            CMD_PRE:        elig[gi] = (pre_t == '0);
            CMD_REF:        elig[gi] = (act_t == '0);
            default:        elig[gi] = 1'b0;
          endcase
        end
      end

      // The max() keeps whichever of tRAS/tWR ends later; the old value is decremented first
      // so an earlier, longer constraint still expires on its original cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_wr_t <= '0;
          act_t   <= '0;
          pre_t   <= '0;
        end else begin
          rd_wr_t <= dec(rd_wr_t);
          act_t   <= dec(act_t);
          pre_t   <= dec(pre_t);
          if (hit) begin
            case (grant_code)
              CMD_ACT: begin
                rd_wr_t <= LD_RCD;
                pre_t   <= max_t(dec(pre_t), LD_RAS);
              end
              CMD_WR:  pre_t <= max_t(dec(pre_t), LD_WR);
              CMD_PRE: act_t <= LD_RP;
              CMD_REF: act_t <= LD_RFC;
              default: ;
            endcase
          end
        end
      end
    end
  endgenerate

  // Rotating priority: scan downwards so the lowest offset from rr_ptr wins; index wraps naturally.
  always_comb begin
    logic [BANK_W-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = NUM_BANKS - 1; k >= 0; k--) begin
      idx = rr_ptr + BANK_W'(k);
      if (elig[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  assign grant_code = bus.req_cmd[3*grant_idx +: 3];
  assign grant_addr = bus.req_addr[ADDR_W*grant_idx +: ADDR_W];
  assign bus.stall  = legal & ~grant_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccd_t         <= '0;
      rrd_t         <= '0;
      rr_ptr        <= '0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_code  <= '0;
      bus.cmd_bank  <= '0;
      bus.cmd_addr  <= '0;
    end else begin
      ccd_t         <= dec(ccd_t);
      rrd_t         <= dec(rrd_t);
      bus.cmd_valid <= grant_valid;
      if (grant_valid) begin
        rr_ptr       <= grant_idx + 1'b1;
        bus.cmd_code <= grant_code;
        bus.cmd_bank <= grant_idx;
        bus.cmd_addr <= grant_addr;
        case (grant_code)
          CMD_ACT:        rrd_t <= LD_RRD;
          CMD_RD, CMD_WR: ccd_t <= LD_CCD;
          default: ;
        endcase
      end
    end
  end
endmodule
